imem_fetch_ctrl: RTL

//  Fetch sequencer for the single-cycle MIPS core. Owns the program counter, drives the

---
 rtl/imem_fetch_ctrl_if.sv | 31 +++
 rtl/imem_fetch_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bundle between the fetch sequencer, the instruction memory and decode.
interface imem_fetch_ctrl_if;
   localparam int unsigned XLEN = 32;

   logic [XLEN-1:0] instr;
   logic            stall;
   logic            branch_en;
   logic [15:0]     branch_imm;
   logic            jump_en;
   logic [25:0]     jump_index;
   logic            resume;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;
   logic            instr_valid;
   logic            halted;
   logic            fault;
   logic [XLEN-1:0] fault_addr;
   logic [XLEN-1:0] retired;

   // Fetch sequencer side
   modport master (
      input  instr, stall, branch_en, branch_imm, jump_en, jump_index, resume,
      output pc, pc_plus4, instr_valid, halted, fault, fault_addr, retired
   );

   // Memory/decode side
   modport slave (
      output instr, stall, branch_en, branch_imm, jump_en, jump_index, resume,
      input  pc, pc_plus4, instr_valid, halted, fault, fault_addr, retired
   );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, selects the next PC, enforces the legal
// instruction window, halts on SYSCALL and latches faults until reset.
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0100,
   parameter logic [31:0] MEM_LO   = 32'h0000_0100,
   parameter logic [31:0] MEM_HI   = 32'h0000_03FC
) (
   input  logic               clk,
   input  logic               reset,
   imem_fetch_ctrl_if.master  bus
);
   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] SYSCALL = 32'h0000_000C;

   typedef enum logic [1:0] {START, RUN, HALT, FAULT} state_t;

   state_t          state, state_next;
   logic [XLEN-1:0] pc, pc_next;
   logic [XLEN-1:0] fault_addr, fault_addr_next;
   logic [XLEN-1:0] retired, retired_next;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] jump_target, branch_target, target;

   // True when addr is word aligned and inside the instruction window
   function automatic logic in_window(input logic [XLEN-1:0] addr);
      return (addr >= MEM_LO) && (addr <= MEM_HI) && (addr[1:0] == 2'b00);
   endfunction

   // Candidate next PC, priority jump > branch > sequential
   always_comb begin
      pc_plus4      = pc + XLEN'(4);
      jump_target   = {pc_plus4[31:28], bus.jump_index, 2'b00};
      branch_target = pc_plus4 + {{14{bus.branch_imm[15]}}, bus.branch_imm, 2'b00};
      if (bus.jump_en)
         target = jump_target;
      else if (bus.branch_en)
         target = branch_target;
      else
         target = pc_plus4;
   end

   // State register and architectural registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= START;
         pc         <= RESET_PC;
         fault_addr <= '0;
         retired    <= '0;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         fault_addr <= fault_addr_next;
         retired    <= retired_next;
      end
   end

   // Next-state, next-PC and retirement decision
   always_comb begin
      state_next      = state;
      pc_next         = pc;
      fault_addr_next = fault_addr;
      retired_next    = retired;
      case (state)
         START: state_next = RUN;
         RUN: begin
            if (!bus.stall) begin
               if (bus.instr == SYSCALL) begin
                  retired_next = retired + XLEN'(1);
                  state_next   = HALT;
               end else if (in_window(target)) begin
                  pc_next      = target;
                  retired_next = retired + XLEN'(1);
               end else begin
                  fault_addr_next = target;
                  state_next      = FAULT;
               end
            end
         end
         HALT: begin
            if (bus.resume) begin
               if (in_window(pc_plus4)) begin
                  pc_next    = pc_plus4;
                  state_next = RUN;
               end else begin
                  fault_addr_next = pc_plus4;
                  state_next      = FAULT;
               end
            end
         end
         FAULT: state_next = FAULT;
         default: state_next = START;
      endcase
   end

   // Output decode
   assign bus.pc          = pc;
   assign bus.pc_plus4    = pc_plus4;
   assign bus.instr_valid = (state == RUN) && !bus.stall;
   assign bus.halted      = (state == HALT);
   assign bus.fault       = (state == FAULT);
   assign bus.fault_addr  = fault_addr;
   assign bus.retired     = retired;
endmodule
